// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone arbiter sharing one RAM slave: round-robin grant, burst-aware
// hold, one idle turnaround cycle between owners and a stalled-strobe watchdog.
module wb_ram_arbiter #(
  parameter int aw      = 32,
  parameter int dw      = 32,
  parameter int timeout = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic [aw-1:0] m0_adr_i,
  input  logic [dw-1:0] m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  input  logic          m0_we_i,
  input  logic [2:0]    m0_cti_i,
  input  logic [1:0]    m0_bte_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  output logic [dw-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic [aw-1:0] m1_adr_i,
  input  logic [dw-1:0] m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  input  logic          m1_we_i,
  input  logic [2:0]    m1_cti_i,
  input  logic [1:0]    m1_bte_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  output logic [dw-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [aw-1:0] s_adr_o,
  output logic [dw-1:0] s_dat_o,
  output logic [3:0]    s_sel_o,
  output logic          s_we_o,
  output logic [2:0]    s_cti_o,
  output logic [1:0]    s_bte_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  input  logic [dw-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  output logic [1:0]    grant_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } state_t;

  localparam logic [7:0] TO = 8'(timeout);

  state_t     r_state, w_next;
  logic       r_last, w_next_last;
  logic [7:0] r_wait_cnt, w_next_cnt;
  logic       w_own_cyc, w_oth_cyc, w_done, w_bound, w_expired, w_in_gnt;
  logic [2:0] w_own_cti;

  // State, last-owner and watchdog registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_next;
      r_last     <= w_next_last;
      r_wait_cnt <= w_next_cnt;
    end
  end

  // Owner-relative view of the bus request and transfer completion.
  always_comb begin
    w_in_gnt = (r_state == GNT0) || (r_state == GNT1);
    if (r_state == GNT1) begin
      w_own_cyc = m1_cyc_i;
      w_oth_cyc = m0_cyc_i;
      w_own_cti = m1_cti_i;
    end else begin
      w_own_cyc = m0_cyc_i;
      w_oth_cyc = m1_cyc_i;
      w_own_cti = m0_cti_i;
    end
    w_done    = s_ack_i | s_err_i;
    w_bound   = (w_own_cti == 3'b000) || (w_own_cti == 3'b111);
    w_expired = (TO != 8'd0) && (r_wait_cnt == TO);
  end

  // Next-state and round-robin bookkeeping; an ack always beats watchdog expiry.
  always_comb begin
    w_next      = r_state;
    w_next_last = r_last;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (r_last) begin
            w_next      = GNT0;
            w_next_last = 1'b0;
          end else begin
            w_next      = GNT1;
            w_next_last = 1'b1;
          end
        end else if (m0_cyc_i) begin
          w_next      = GNT0;
          w_next_last = 1'b0;
        end else if (m1_cyc_i) begin
          w_next      = GNT1;
          w_next_last = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      GNT0, GNT1: begin
        if (!w_own_cyc) begin
          w_next = IDLE;
        end else if (w_done && w_bound && w_oth_cyc) begin
          w_next = IDLE;
        end else if (w_done) begin
          w_next = r_state;
        end else if (w_expired) begin
          w_next = ABORT;
        end else begin
          w_next = r_state;
        end
      end
      ABORT:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Watchdog counts stalled strobe cycles of the current owner only.
  always_comb begin
    w_next_cnt = 8'd0;
    if (w_in_gnt && (w_next == r_state) && !w_done && s_stb_o && (TO != 8'd0)) begin
      if (r_wait_cnt == TO) begin
        w_next_cnt = r_wait_cnt;
      end else begin
        w_next_cnt = r_wait_cnt + 8'd1;
      end
    end else begin
      w_next_cnt = 8'd0;
    end
  end

  // Slave-side mux and master responses, combinational from the registered owner.
  always_comb begin
    s_adr_o  = m0_adr_i;
    s_dat_o  = m0_dat_i;
    s_sel_o  = m0_sel_i;
    s_we_o   = m0_we_i;
    s_cti_o  = m0_cti_i;
    s_bte_o  = m0_bte_i;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = 2'b00;
    case (r_state)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i;
        grant_o  = 2'b01;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i;
        grant_o  = 2'b10;
      end
      ABORT: begin
        m0_err_o = ~r_last;
        m1_err_o = r_last;
      end
      default: begin
        grant_o = 2'b00;
      end
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: doc/wb_ram_arbiter.md
Name: wb_ram_arbiter

Overview:
- Two-master Wishbone arbiter that shares one single-port Wishbone RAM slave (32-bit, classic and incrementing burst) between two requesters, e.g. CPU instruction and data buses.
- Round-robin grant, burst-aware hold, one-cycle bus turnaround between owners, and a watchdog that aborts stalled transfers with an error.
- Sits between the two masters and the RAM's Wishbone slave port.

Parameters:
aw, 32, address width of master and slave address buses
dw, 32, data width
timeout, 255, cycles of stalled strobe before abort; 0 disables the watchdog (max 255, 8-bit counter)

Ports:
wb_clk_i  input  1  single clock; all state on rising edge
wb_rst_ni  input  1  reset, asynchronous, active-low
m0_adr_i / m1_adr_i  input  aw  master address
m0_dat_i / m1_dat_i  input  dw  master write data
m0_sel_i / m1_sel_i  input  4  byte selects
m0_we_i / m1_we_i  input  1  write enable
m0_cti_i / m1_cti_i  input  3  cycle type identifier
m0_bte_i / m1_bte_i  input  2  burst type extension
m0_cyc_i / m1_cyc_i  input  1  cycle / bus request
m0_stb_i / m1_stb_i  input  1  strobe
m0_dat_o / m1_dat_o  output  dw  read data (s_dat_i broadcast to both)
m0_ack_o / m1_ack_o  output  1  acknowledge, granted master only
m0_err_o / m1_err_o  output  1  error, granted master only, or watchdog abort
s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o  output  aw/dw/4/1/3/2  muxed from granted master
s_cyc_o, s_stb_o  output  1  granted master's cyc/stb, gated by grant
s_dat_i  input  dw  slave read data
s_ack_i, s_err_i  input  1  slave ack / error
grant_o  output  2  one-hot current owner; 00 when idle or aborting

Behaviour:
- States: IDLE, GNT0, GNT1, ABORT. Registers: state, last (last granted master), wait_cnt[7:0].
- Reset (wb_rst_ni low, async): state=IDLE, last=1 (m0 wins first tie), wait_cnt=0. Outputs: grant_o=00, s_cyc_o=s_stb_o=0, all m*_ack_o/m*_err_o=0.
- Slave-side outputs and master ack/err are combinational from registered state. They are not registered, so slave ack latency passes through unchanged.
- In GNTn: s_* = mn_*. mn_ack_o = s_ack_i and mn_err_o = s_err_i. The other master sees ack=err=0.
- In IDLE and ABORT: s_cyc_o=s_stb_o=0. Other s_* outputs are don't-care but driven from m0.
- IDLE -> GNTn at the next edge after mn_cyc_i sampled high.
  - If both request, grant the master != last.
  - last is updated to n on entry.
  - Grant latency is 1 cycle from request.
- GNTn -> IDLE when either holds:
  - (a) mn_cyc_i sampled low.
  - (b) s_ack_i or s_err_i this cycle, mn_cti_i is 000 or 111, and the other master's cyc_i is high. This enforces fairness at transaction boundaries.
  - If only mn requests, the grant holds indefinitely, including across back-to-back classic cycles.
- The mandatory IDLE cycle guarantees s_stb_o drops between owners, so the slave detects a new cycle and reloads its address. Handover latency is 2 cycles.
- A master losing grant under (b) with cyc still high simply waits. Its stb is not forwarded and it receives no ack.
- Watchdog, when timeout != 0:
  - wait_cnt increments each GNTn cycle with s_stb_o=1 and s_ack_i=s_err_i=0.
  - It clears on ack, on err, or on leaving GNTn, and saturates at timeout.
  - When wait_cnt == timeout at an edge, go to ABORT.
- ABORT lasts exactly 1 cycle:
  - Aborted master's err_o=1; s_cyc_o=0.
  - Next state IDLE. last keeps the aborted master, so the other master gets priority.
- Simultaneous ack and watchdog expiry: ack wins and the counter clears, with no abort.
- Reset mid-burst: immediate return to IDLE with outputs deasserted asynchronously. Masters must restart.

Test Plan:
- Reset then m0 single read (cti=000), slave acks 1 cycle after stb -> s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o mirrors s_ack_i; m1_ack_o=0; grant_o=01.
- m0 and m1 raise cyc in the same cycle, each issues 3 classic reads with cyc held -> grants alternate m0,m1,m0,m1,m0,m1; one idle cycle with s_stb_o=0 between each owner change.
- m0 4-beat incrementing burst (cti=010,010,010,111), m1 requests at beat 2 -> m0 keeps grant for all 4 acks; grant_o goes 01->00->10 two cycles after the final ack.
- timeout=4, m0 stb with slave never acking -> s_stb_o high 5 cycles, then ABORT: m0_err_o=1 for exactly 1 cycle, s_cyc_o=0; m1 granted next if requesting.
- Ack arriving in the same cycle wait_cnt reaches timeout -> no m0_err_o, no ABORT, transfer completes normally.
- wb_rst_ni pulsed low mid-burst while GNT1 -> s_cyc_o, s_stb_o, grant_o, m1_ack_o drop in the same cycle without waiting for a clock edge; after release, a tie grants m0 first.
